// File: rtl/mdseq_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, op codes, default step counts.
package mdseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int MUL_STEPS_DEF = 13;
  localparam int DIV_STEPS_DEF = 26;
  localparam int CNT_W_DEF     = 5;

endpackage

// File: rtl/mdseq_arb.sv
// Two-way request arbiter, one-hot grant. Fixed priority to requester 0 unless
// MDSEQ_ROUND_ROBIN_EN is defined, which adds a 1-bit round-robin pointer.
module mdseq_arb (
`ifdef MDSEQ_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xfer,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

`ifdef MDSEQ_ROUND_ROBIN_EN
  // ptr names the requester preferred on a tie; it moves to the loser on every transfer
  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (xfer) begin
      ptr <= grant[0];
    end
  end
`endif

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef MDSEQ_ROUND_ROBIN_EN
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
`else
      2'b11:   grant = 2'b01;
`endif
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide controller: arbitrates two requesters, then LOAD, N gated steps, FIXUP, result hold until ACK.
// Tie-break is fixed priority by default, round-robin with MDSEQ_ROUND_ROBIN_EN defined.
module md_sequencer
  import mdseq_pkg::*;
#(
  parameter int MUL_STEPS = MUL_STEPS_DEF,
  parameter int DIV_STEPS = DIV_STEPS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             STEP_EN,
  input  logic [1:0]       REQ_VALID,
  input  logic [1:0]       REQ_OP,
  output logic [1:0]       REQ_READY,
  output logic             GNT_ID,
  output logic             OP_DIV,
  output logic             LD_OPS,
  output logic             MSTEP,
  output logic             DSTEP,
  output logic             FIXUP,
  input  logic             DIV_ZERO,
  output logic [CNT_W-1:0] STEP_CNT,
  output logic             BUSY,
  output logic             RES_VALID,
  output logic             RES_ERR,
  input  logic             RES_ACK
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [1:0]       grant;
  logic             idle;
  logic             xfer;

  assign idle = (state_q == S_IDLE);
  assign xfer = idle & (|grant);

  mdseq_arb u_arb (
`ifdef MDSEQ_ROUND_ROBIN_EN
    .clk   (CLK),
    .rst_n (RESETN),
    .xfer  (xfer),
`endif
    .valid (REQ_VALID),
    .grant (grant)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          id_d    = grant[1];
          op_d    = REQ_OP[grant[1]];
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q == mdseq_pkg::OP_DIV && DIV_ZERO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = (op_q == mdseq_pkg::OP_DIV) ? DIV_LAST : MUL_LAST;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // the step taken at count zero is the last one, so N strobes in total
        if (STEP_EN) begin
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (RES_ACK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign REQ_READY = idle ? grant : 2'b00;
  assign GNT_ID    = id_q;
  assign OP_DIV    = op_q;
  assign LD_OPS    = (state_q == S_LOAD);
  assign MSTEP     = (state_q == S_RUN) & STEP_EN & (op_q == OP_MUL);
  assign DSTEP     = (state_q == S_RUN) & STEP_EN & (op_q == mdseq_pkg::OP_DIV);
  assign FIXUP     = (state_q == S_FIX);
  assign STEP_CNT  = cnt_q;
  assign BUSY      = !idle;
  assign RES_VALID = (state_q == S_DONE);
  assign RES_ERR   = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed scenarios then randomized ops against a transaction-level model.
module tb_md_sequencer;

`ifdef MDSEQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       CLK, RESETN, STEP_EN, DIV_ZERO, RES_ACK;
  logic [1:0] REQ_VALID, REQ_OP, REQ_READY;
  logic       GNT_ID, OP_DIV, LD_OPS, MSTEP, DSTEP, FIXUP, BUSY, RES_VALID, RES_ERR;
  logic [4:0] STEP_CNT;

  md_sequencer dut (
    .CLK(CLK), .RESETN(RESETN), .STEP_EN(STEP_EN),
    .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP), .REQ_READY(REQ_READY),
    .GNT_ID(GNT_ID), .OP_DIV(OP_DIV), .LD_OPS(LD_OPS),
    .MSTEP(MSTEP), .DSTEP(DSTEP), .FIXUP(FIXUP),
    .DIV_ZERO(DIV_ZERO), .STEP_CNT(STEP_CNT), .BUSY(BUSY),
    .RES_VALID(RES_VALID), .RES_ERR(RES_ERR), .RES_ACK(RES_ACK)
  );

  typedef struct {
    logic id;
    logic op;
    logic err;
    int   msteps;
    int   dsteps;
    int   lat;     // cycles from LD_OPS to first RES_VALID, -1 when STEP_EN is irregular
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_mode = 0;   // 0: STEP_EN high, 4: every 4th cycle, else random
  int   rr_ptr = 0;      // model of the preferred requester on a tie

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    int tick = 0;
    STEP_EN = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (step_mode)
        0:       STEP_EN = 1'b1;
        4:       STEP_EN = (tick % 4 == 0);
        default: STEP_EN = 1'($urandom_range(0, 1));
      endcase
      tick++;
    end
  end

  // monitor: tracks each op from LD_OPS to acknowledged result and scores it
  initial begin
    bit   active = 0, in_done = 0, idle_chk = 0;
    int   mc = 0, dc = 0, fx = 0, lat = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        active = 0; in_done = 0; idle_chk = 0;
        continue;
      end
      if (idle_chk) begin
        chk("idle_after_ack", int'({BUSY, RES_VALID}), 0);
        idle_chk = 0;
      end
      if (LD_OPS) begin
        chk("ld_while_active", int'(active), 0);
        active = 1; in_done = 0; mc = 0; dc = 0; fx = 0; lat = 0;
      end else if (active) begin
        lat++;
      end
      if (!active) begin
        chk("stray_strobe", int'({MSTEP, DSTEP, FIXUP, RES_VALID}), 0);
      end else begin
        chk("ready_while_busy", int'(REQ_READY), 0);
        if (MSTEP || DSTEP) chk("step_without_en", int'(STEP_EN), 1);
        mc += int'(MSTEP);
        dc += int'(DSTEP);
        fx += int'(FIXUP);
        if (RES_VALID && !in_done) begin
          in_done = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("gnt_id",  int'(GNT_ID),  int'(e.id));
            chk("op_div",  int'(OP_DIV),  int'(e.op));
            chk("res_err", int'(RES_ERR), int'(e.err));
            chk("msteps",  mc, e.msteps);
            chk("dsteps",  dc, e.dsteps);
            chk("fixups",  fx, e.err ? 0 : 1);
            if (e.lat >= 0) chk("latency", lat, e.lat);
          end
        end
        if (in_done) begin
          chk("res_valid_held", int'(RES_VALID), 1);
          if (RES_ACK) begin
            active = 0; in_done = 0; idle_chk = 1;
          end
        end
      end
    end
  end

  // Entered and left at #1 after a posedge in an IDLE cycle.
  task automatic do_op(input logic [1:0] vld, input logic [1:0] ops, input logic dz,
                       input int mode, input int ack_dly);
    int   w, n, nsteps;
    exp_t e;
    step_mode = mode;
    if (vld == 2'b10)      w = 1;
    else if (vld == 2'b01) w = 0;
    else                   w = RR ? rr_ptr : 0;
    e.id     = 1'(w);
    e.op     = ops[w];
    e.err    = e.op & dz;
    nsteps   = e.op ? 26 : 13;
    e.msteps = (!e.err && !e.op) ? 13 : 0;
    e.dsteps = (!e.err &&  e.op) ? 26 : 0;
    e.lat    = (mode != 0) ? -1 : (e.err ? 1 : nsteps + 2);
    exp_q.push_back(e);
    REQ_VALID = vld;
    REQ_OP    = ops;
    DIV_ZERO  = dz;
    @(negedge CLK);
    chk("req_ready", int'(REQ_READY), 1 << w);
    @(posedge CLK);
    #1;
    REQ_VALID[w] = 1'b0;
    rr_ptr = 1 - w;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!RES_VALID && n < 600);
    chk("res_valid_timeout", int'(RES_VALID), 1);
    repeat (ack_dly) @(posedge CLK);
    @(posedge CLK);
    #1;
    RES_ACK   = 1'b1;
    REQ_VALID = 2'b00;
    @(posedge CLK);
    #1;
    RES_ACK = 1'b0;
  endtask

  initial begin
    int n;
    RESETN = 1'b0; REQ_VALID = 2'b00; REQ_OP = 2'b00; DIV_ZERO = 1'b0; RES_ACK = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", int'({REQ_READY, GNT_ID, OP_DIV, LD_OPS, MSTEP, DSTEP, FIXUP,
                             STEP_CNT, BUSY, RES_VALID, RES_ERR}), 0);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    do_op(2'b01, 2'b00, 1'b0, 0, 0);   // multiply, req0, full rate
    do_op(2'b01, 2'b01, 1'b1, 0, 0);   // divide by zero
    do_op(2'b10, 2'b10, 1'b0, 4, 0);   // divide, req1, sparse STEP_EN
    do_op(2'b11, 2'b00, 1'b0, 0, 10);  // result held off, other requester waiting

    // abandon a divide mid-run
    step_mode = 0;
    REQ_VALID = 2'b01; REQ_OP = 2'b01; DIV_ZERO = 1'b0;
    @(posedge CLK);
    #1;
    REQ_VALID = 2'b00;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (STEP_CNT != 5'd5 && n < 100);
    chk("reach_cnt5", int'(STEP_CNT), 5);
    RESETN = 1'b0;
    @(negedge CLK);
    chk("reset_midop", int'({REQ_READY, GNT_ID, OP_DIV, LD_OPS, MSTEP, DSTEP, FIXUP,
                             STEP_CNT, BUSY, RES_VALID, RES_ERR}), 0);
    RESETN = 1'b1;
    rr_ptr = 0;
    repeat (10) @(negedge CLK);
    @(posedge CLK);
    #1;

    // contention from a fresh pointer
    for (int i = 0; i < 3; i++) do_op(2'b11, 2'($urandom_range(0, 3)), 1'b0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      logic [1:0] v;
      int         m;
      v = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 2))
        0:       m = 0;
        1:       m = 4;
        default: m = 7;
      endcase
      do_op(v, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), m,
            int'($urandom_range(0, 5)));
    end

    repeat (5) @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
